// File: rtl/encoder_16to4_stream.sv
// Streaming 16-to-4 priority encoder: accepts a 16-bit request vector and emits
// the index of every set bit, one beat per handshake, in LSB- or MSB-first order.
module encoder_16to4_stream #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_vec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_code,
  output logic        out_last,
  output logic        out_none,
  output logic        busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] pending_r, pending_s;
  logic        none_r, none_s;
  logic [3:0]  code_s;
  logic        last_s;
  logic        fire_s;

  function automatic logic [3:0] pick_index(input logic [15:0] v, input bit lsb_first);
    logic [3:0] idx;
    idx = 4'd0;
    if (lsb_first) begin
      for (int i = 15; i >= 0; i--) begin
        if (v[i]) idx = 4'(i);
        else      idx = idx;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (v[i]) idx = 4'(i);
        else      idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic at_most_one(input logic [15:0] v);
    return ((v & (v - 16'd1)) == 16'd0);
  endfunction

  // Next-state and pending-vector update for the accept/scan handshakes.
  always_comb begin
    state_s   = state_r;
    pending_s = pending_r;
    none_s    = none_r;
    code_s    = pick_index(pending_r, LSB_FIRST);
    last_s    = at_most_one(pending_r);
    fire_s    = out_valid & out_ready;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          pending_s = in_vec;
          none_s    = (in_vec == 16'd0);
          state_s   = SCAN;
        end else begin
          state_s   = IDLE;
        end
      end
      SCAN: begin
        if (fire_s) begin
          pending_s = pending_r & ~(16'd1 << code_s);
          none_s    = 1'b0;
          if (last_s) state_s = IDLE;
          else        state_s = SCAN;
        end else begin
          state_s = SCAN;
        end
      end
      default: begin
        state_s   = IDLE;
        pending_s = 16'd0;
        none_s    = 1'b0;
      end
    endcase
  end

  // State and pending-vector registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pending_r <= 16'd0;
      none_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      pending_r <= pending_s;
      none_r    <= none_s;
    end
  end

  // Outputs are registered from the next state so they present with one cycle
  // of latency and stay frozen whenever no handshake occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_code  <= 4'd0;
      out_last  <= 1'b0;
      out_none  <= 1'b0;
    end else begin
      in_ready  <= (state_s == IDLE);
      out_valid <= (state_s == SCAN);
      busy      <= (state_s == SCAN);
      out_code  <= pick_index(pending_s, LSB_FIRST);
      out_last  <= (state_s == SCAN) ? at_most_one(pending_s) : 1'b0;
      out_none  <= none_s;
    end
  end

endmodule
